// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default parameters and index-width helper for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  localparam int NREQ_DEF = 4;
  localparam int DONE_ADDR_DEF = 252;
  localparam int TIMEOUT_DEF = 160;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: per-core request bus plus the shared memory port
interface mem_arbiter_if import mem_arb_pkg::*; #(parameter int NREQ = NREQ_DEF);
  logic [NREQ-1:0] req, we, gnt, rvalid;
  logic [NREQ-1:0][31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_we;
  modport slave (
    input req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the index just after the last grant
module rr_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  localparam int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);
  logic [IW-1:0] cand;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx = cand;
      end
    end
    gnt = valid ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one data memory among NREQ cores, with done/score capture and a watchdog
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int DONE_ADDR = DONE_ADDR_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_arbiter_if.slave           bus,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0][31:0]  score,
  output logic                   all_done,
  output logic                   timeout
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [IW-1:0] win, widx;
  logic [NREQ-1:0] sel, wgnt, done_nxt;
  logic any, hit;
  logic [CW-1:0] cnt, cnt_nxt;
  // win doubles as the last-granted index; resetting it to NREQ-1 puts core 0 first
  rr_arbiter #(.NREQ(NREQ)) u_rr (.req(bus.req), .last(win), .gnt(wgnt), .idx(widx), .valid(any));
  assign cnt_nxt = cnt == CW'(TIMEOUT) ? cnt : cnt + CW'(1);
  always_comb begin
    nxt = state;
    bus.gnt = '0;
    bus.rvalid = '0;
    bus.rdata = '0;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    hit = 1'b0;
    done_nxt = done;
    unique case (state)
      IDLE: nxt = any ? ISSUE : IDLE;
      ISSUE: begin
        bus.gnt = sel;
        bus.mem_we = bus.we[win];
        bus.mem_addr = bus.addr[win];
        bus.mem_wdata = bus.wdata[win];
        hit = bus.we[win] && bus.addr[win] == 32'(DONE_ADDR) && !done[win];
        done_nxt[win] = done[win] | hit;
        nxt = bus.we[win] ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        bus.rvalid = sel;
        bus.rdata = bus.mem_rdata;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      win <= IW'(NREQ - 1);
      sel <= '0;
      done <= '0;
      score <= '0;
      cnt <= '0;
      all_done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        win <= widx;
        sel <= wgnt;
      end
      if (hit) score[win] <= bus.wdata[win];
      done <= done_nxt;
      cnt <= cnt_nxt;
      all_done <= all_done | &done_nxt;
      // finishing on the very cycle the limit is hit counts as finishing in time
      timeout <= timeout | (cnt_nxt == CW'(TIMEOUT) && !(&done_nxt));
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed phases plus random traffic checked against a transaction-level schedule model
module tb_mem_arbiter;
  localparam int N = 4, TO = 160, DA = 252, INF = 1 << 30;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] done;
  logic [N-1:0][31:0] score;
  logic all_done, timeout;
  mem_arbiter_if #(.NREQ(N)) bus();
  mem_arbiter #(.NREQ(N), .DONE_ADDR(DA), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .done(done), .score(score),
    .all_done(all_done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  logic [31:0] tmem [64] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_we) tmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= tmem[bus.mem_addr[7:2]];
  end
  int checks = 0, failures = 0;
  int c, eg, erv, ew, free, done_time, last, ng;
  logic e_we;
  logic [31:0] e_ad, e_wd, erd, lrd;
  logic [31:0] mm [64];
  logic [31:0] pad [N], pwd [N], m_score [N];
  logic [N-1:0] p, pwe, m_done, no252;
  bit rnd, hold, fin;
  int gq[$], gcq[$];
  int lg [N], lrv [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    p[i] = 1'b1; pwe[i] = w; pad[i] = a; pwd[i] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_done"}, 32'(done), 0);
    for (int i = 0; i < N; i++) chk({tag, "_score"}, score[i], 0);
    chk({tag, "_all_done"}, 32'(all_done), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic body(input bit ck);
    logic w;
    logic [31:0] a;
    int j, win;
    if (ck) begin
      chk("gnt", 32'(bus.gnt), c == eg ? 32'(1) << ew : 32'd0);
      chk("rvalid", 32'(bus.rvalid), c == erv ? 32'(1) << ew : 32'd0);
      if (c == erv) chk("rdata", bus.rdata, erd);
      chk("mem_we", 32'(bus.mem_we), 32'(c == eg && e_we));
      if (c == eg) begin
        chk("mem_addr", bus.mem_addr, e_ad);
        chk("mem_wdata", bus.mem_wdata, e_wd);
      end
      chk("done", 32'(done), 32'(m_done));
      for (int i = 0; i < N; i++) chk("score", score[i], m_score[i]);
      chk("all_done", 32'(all_done), 32'(c >= done_time));
      chk("timeout", 32'(timeout), 32'(c >= TO && done_time > TO));
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin gq.push_back(i); gcq.push_back(c); lg[i] = c; ng++; end
        if (bus.rvalid[i]) begin lrv[i] = c; lrd = bus.rdata; end
      end
    end
    if (c == eg && e_we) begin
      mm[e_ad[7:2]] = e_wd;
      if (e_ad == DA && !m_done[ew]) begin
        m_done[ew] = 1'b1;
        m_score[ew] = e_wd;
        if (&m_done) done_time = c + 1;
      end
    end
    if (c == eg + 1) p[ew] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!p[i] && hold) post(i, 1'b1, 32'(i * 4), i == 2 ? 32'h1234 : 32'(32'h100 + i));
      else if (!p[i] && rnd && ($urandom % 4 == 0 || (fin && c >= 40 && !m_done[i]))) begin
        w = 1'($urandom % 2);
        a = 32'($urandom_range(0, 63) * 4);
        if (fin && c >= 40 && !m_done[i]) begin w = 1'b1; a = DA; end
        if (no252[i] && a == DA) a = DA - 4;
        post(i, w, a, $urandom);
      end else if (p[i] && rnd && !(i == ew && c <= eg) && $urandom % 32 == 0) p[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      bus.req[i] = p[i];
      if (p[i]) begin bus.we[i] = pwe[i]; bus.addr[i] = pad[i]; bus.wdata[i] = pwd[i]; end
    end
    if (c >= free && |p) begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        j = (last + k) % N;
        if (win < 0 && p[j]) win = j;
      end
      ew = win; eg = c + 1; last = win;
      e_we = pwe[win]; e_ad = pad[win]; e_wd = pwd[win];
      free = c + (e_we ? 2 : 3);
      erv = e_we ? -10 : c + 2;
      erd = mm[e_ad[7:2]];
    end
  endtask

  task automatic step();
    @(negedge clk);
    c++;
    body(1'b1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst");
    p = '0; bus.req = '0; bus.we = '0;
    m_done = '0; done_time = INF; last = N - 1; free = 0;
    eg = -10; erv = -10; ew = 0;
    for (int i = 0; i < N; i++) m_score[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    c = 0;
    body(1'b0);
  endtask

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 64; i++) mm[i] = '0;
    rnd = 0; hold = 0; fin = 0; no252 = '0; ng = 0;
    #1 chk_zero("init");
    do_reset();
    // all four cores keep requesting writes
    hold = 1;
    run(10);
    hold = 0;
    chk("rr_count", 32'(gq.size() >= 5), 1);
    for (int k = 0; k < 5 && k < gq.size(); k++) chk("rr_order", gq[k], k % 4);
    for (int k = 1; k < 5 && k < gq.size(); k++) chk("rr_gap", gcq[k] - gcq[k - 1], 2);
    run(12);
    // core 2 reads back the value it wrote at address 8
    lg[2] = -1; lrv[2] = -1;
    post(2, 1'b0, 8, 0);
    run(6);
    chk("rd_gnt_seen", 32'(lg[2] >= 0), 1);
    chk("rd_latency", lrv[2] - lg[2], 1);
    chk("rd_data", lrd, 32'h1234);
    post(1, 1'b1, DA, 9);
    run(4);
    post(1, 1'b1, DA, 5);
    run(4);
    chk("done1", 32'(done[1]), 1);
    chk("score1", score[1], 9);
    // random traffic where core 3 never finishes
    rnd = 1; no252[3] = 1'b1;
    while (c < TO) step();
    chk("to_set", 32'(timeout), 1);
    chk("to_not_done", 32'(all_done), 0);
    ng = 0;
    while (c < 200) step();
    chk("arb_after_to", 32'(ng > 0), 1);
    rnd = 0;
    run(20);
    // reset in the middle of a read
    post(2, 1'b0, 8, 0);
    step();
    step();
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_zero("rdwait_rst");
    do_reset();
    lrv[2] = -1;
    for (int i = 0; i < N; i++) post(i, 1'b1, 32'(16 + 4 * i), $urandom);
    gq.delete(); gcq.delete();
    run(3);
    chk("first_after_rst", gq.size() > 0 ? gq[0] : -1, 0);
    chk("no_stale_rvalid", lrv[2], -1);
    // random traffic where every core finishes early
    rnd = 1; fin = 1; no252 = '0;
    while (c < 170) step();
    chk("all_done_set", 32'(all_done), 1);
    chk("all_done_no_to", 32'(timeout), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
